uart_rx_frontend: RTL and testbench

- UART receive front end that deserialises the board-level `uart_rx` pin (8N1, LSB first, 115200 baud default) into bytes.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream to the accelerator's host command path inside the FPGA top.
- Sits directly upstream of the top-level command/control logic; it is the consumer of the UART pin.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 64 ++++++
 rtl/uart_rx_frontend.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the RX front end and its FIFO
// (the FIFO is also shared with the TX path).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } uart_rx_state_e;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_DEFAULT_CLKS_PER_BIT = 2170;

   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with push/pop/full/empty/level; DEPTH must be a power of two.
// The head reads as zero while the FIFO is empty.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] LVL_ZERO = {(AW+1){1'b0}};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      level_q;
   logic             wr_en_s;
   logic             rd_en_s;

   assign full_o  = (level_q == LVL_FULL);
   assign empty_o = (level_q == LVL_ZERO);
   assign level_o = level_q;
   assign head_o  = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign rd_en_s = pop_i && !empty_o;
   assign wr_en_s = push_i && (!full_o || rd_en_s);

   always_ff @(posedge clock) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= LVL_ZERO;
      end else begin
         if (wr_en_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (rd_en_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({wr_en_s, rd_en_s})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receiver feeding a small byte FIFO on a valid/ready stream.
// Define UART_RX_PARITY_EN to expect an even parity bit between data and stop.
module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        uart_rx,
   output logic                        out_valid,
   output logic [7:0]                  out_data,
   input  logic                        out_ready,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        err_frame,
   output logic                        err_overrun,
   output logic                        err_parity,
   input  logic                        err_clear
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

   logic                      sync1_q;
   logic                      sync2_q;
   logic                      rx_s;
   uart_rx_state_e            state_q;
   logic [CNT_W-1:0]          baud_q;
   logic [2:0]                idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      busy_q;
   logic                      bit_done_s;
   logic                      half_done_s;
   logic                      stop_tick_s;
   logic                      push_s;
   logic                      pop_s;
   logic                      frame_err_s;
   logic                      overrun_s;
   logic                      par_bad_s;
   logic                      fifo_full_s;
   logic                      fifo_empty_s;
   logic                      err_frame_q;
   logic                      err_frame_d;
   logic                      err_overrun_q;
   logic                      err_overrun_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= uart_rx;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s        = sync2_q;
   assign bit_done_s  = (baud_q == CNT_FULL);
   assign half_done_s = (baud_q == CNT_HALF);
   assign stop_tick_s = (state_q == STOP) && bit_done_s;
   assign push_s      = stop_tick_s && rx_s && !par_bad_s;
   assign frame_err_s = stop_tick_s && !rx_s;
   assign pop_s       = out_valid && out_ready;
   assign overrun_s   = push_s && fifo_full_s && !pop_s;

   // The baud counter restarts from zero on every state change.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= CNT_ZERO;
         idx_q   <= 3'd0;
         shift_q <= {UART_DATA_BITS{1'b0}};
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               baud_q <= CNT_ZERO;
               if (!rx_s) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (half_done_s) begin
                  baud_q <= CNT_ZERO;
                  if (rx_s) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DATA;
                     idx_q   <= 3'd0;
                  end
               end else begin
                  baud_q <= baud_q + CNT_ONE;
               end
            end
            DATA: begin
               if (bit_done_s) begin
                  baud_q         <= CNT_ZERO;
                  shift_q[idx_q] <= rx_s;
                  if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q + CNT_ONE;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_done_s) begin
                  baud_q  <= CNT_ZERO;
                  state_q <= STOP;
               end else begin
                  baud_q <= baud_q + CNT_ONE;
               end
            end
`endif
            STOP: begin
               if (bit_done_s) begin
                  baud_q <= CNT_ZERO;
                  if (rx_s) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= WAIT_HIGH;
                  end
               end else begin
                  baud_q <= baud_q + CNT_ONE;
               end
            end
            WAIT_HIGH: begin
               baud_q <= CNT_ZERO;
               if (rx_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               baud_q  <= CNT_ZERO;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad_q;
   logic parity_err_s;
   logic err_parity_q;
   logic err_parity_d;

   assign parity_err_s = (state_q == PARITY) && bit_done_s && (rx_s != even_parity(shift_q));
   assign par_bad_s    = par_bad_q;
   assign err_parity_d = parity_err_s | (err_parity_q & ~err_clear);
   assign err_parity   = err_parity_q;

   // A bad parity bit condemns the byte until the stop bit is sampled.
   always_ff @(posedge clock) begin
      if (reset) begin
         par_bad_q    <= 1'b0;
         err_parity_q <= 1'b0;
      end else begin
         err_parity_q <= err_parity_d;
         if (parity_err_s) begin
            par_bad_q <= 1'b1;
         end else if (stop_tick_s) begin
            par_bad_q <= 1'b0;
         end
      end
   end
`else
   assign par_bad_s  = 1'b0;
   assign err_parity = 1'b0;
`endif

   // Set has priority over clear.
   always_comb begin
      err_frame_d   = frame_err_s | (err_frame_q & ~err_clear);
      err_overrun_d = overrun_s | (err_overrun_q & ~err_clear);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         err_frame_q   <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         err_frame_q   <= err_frame_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (push_s),
      .push_data_i (shift_q),
      .pop_i       (pop_s),
      .head_o      (out_data),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s),
      .level_o     (fifo_level)
   );

   assign out_valid   = !fifo_empty_s;
   assign busy        = busy_q;
   assign err_frame   = err_frame_q;
   assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend (CLKS_PER_BIT=16, FIFO_DEPTH=4),
// with a frame-timing reference model and directed plus random frames.
module tb_uart_rx_frontend;

   localparam int C  = 16;
   localparam int H  = C / 2;
   localparam int D  = 4;
   localparam int LW = $clog2(D) + 1;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          uart_rx = 1'b1;
   logic          out_ready = 1'b0;
   logic          err_clear = 1'b0;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          busy;
   logic [LW-1:0] fifo_level;
   logic          err_frame;
   logic          err_overrun;
   logic          err_parity;

   uart_rx_frontend #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clock       (clock),
      .reset       (reset),
      .uart_rx     (uart_rx),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .busy        (busy),
      .fifo_level  (fifo_level),
      .err_frame   (err_frame),
      .err_overrun (err_overrun),
      .err_parity  (err_parity),
      .err_clear   (err_clear)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   bit rand_mode = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: the pin reaches the receiver two edges late; a frame detected at
   // edge t0 is checked at t0+H and then sampled every C edges (data, parity, stop).
   logic [7:0] mq[$];
   logic       hist[$];
   int         mode = 0;
   int         t0 = 0;
   int         n_edge = 0;
   logic [7:0] msh = 8'h00;
   bit         mpar_bad = 1'b0;
   bit         m_ef = 1'b0, m_eo = 1'b0, m_ep = 1'b0;

   always @(posedge clock) begin : model
      logic rx_m, pop_m, psh, fe, oe, pe;
      int off, k;
      n_edge = n_edge + 1;
      if (reset) begin
         mq.delete();
         hist.delete();
         hist.push_back(1'b1);
         hist.push_back(1'b1);
         mode = 0; mpar_bad = 1'b0;
         m_ef = 1'b0; m_eo = 1'b0; m_ep = 1'b0;
      end else begin
         hist.push_back(uart_rx);
         rx_m = hist[hist.size()-3];
         if (hist.size() > 3) void'(hist.pop_front());
         pop_m = out_ready && (mq.size() > 0);
         psh = 1'b0; fe = 1'b0; oe = 1'b0; pe = 1'b0;
         if (mode == 0) begin
            if (!rx_m) begin mode = 1; t0 = n_edge; end
         end else if (mode == 2) begin
            if (rx_m) mode = 0;
         end else begin
            off = n_edge - t0;
            if (off == H) begin
               if (rx_m) mode = 0;
            end else if (off > H && ((off - H) % C) == 0) begin
               k = (off - H) / C - 1;
               if (k < 8) begin
                  msh[k] = rx_m;
               end else if (k == 8 && P == 1) begin
                  if (rx_m != ^msh) begin pe = 1'b1; mpar_bad = 1'b1; end
               end else begin
                  if (rx_m) begin
                     if (!mpar_bad) psh = 1'b1;
                     mode = 0;
                  end else begin
                     fe = 1'b1;
                     mode = 2;
                  end
                  mpar_bad = 1'b0;
               end
            end
         end
         if (pop_m) void'(mq.pop_front());
         if (psh) begin
            if (mq.size() < D) mq.push_back(msh);
            else oe = 1'b1;
         end
         m_ef = fe | (m_ef & ~err_clear);
         m_eo = oe | (m_eo & ~err_clear);
         m_ep = pe | (m_ep & ~err_clear);
      end
   end

   // Every-cycle comparison, sampled 2 time units after the edge; also logs consumed bytes.
   logic       prev_valid = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] rxlog[$];

   always @(posedge clock) begin : compare
      #2;
      if (!reset && prev_valid && out_ready) rxlog.push_back(prev_data);
      prev_valid = out_valid;
      prev_data  = out_data;
      check("out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
      check("out_data", int'(out_data), (mq.size() > 0) ? int'(mq[0]) : 0);
      check("fifo_level", int'(fifo_level), mq.size());
      check("busy", int'(busy), (mode != 0) ? 1 : 0);
      check("err_frame", int'(err_frame), int'(m_ef));
      check("err_overrun", int'(err_overrun), int'(m_eo));
      check("err_parity", int'(err_parity), int'(m_ep));
   end

   task automatic bit_cycles(input logic v, input int ncyc);
      uart_rx = v;
      repeat (ncyc) begin
         @(negedge clock);
         if (rand_mode) begin
            out_ready = 1'($urandom_range(0, 1));
            err_clear = ($urandom_range(0, 31) == 0);
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_bit);
      bit_cycles(1'b0, C);
      for (int i = 0; i < 8; i++) bit_cycles(d[i], C);
      if (P == 1) bit_cycles(par_bit, C);
      bit_cycles(stop_bit, C);
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(negedge clock);
      err_clear = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      int stop_edge;
      logic [7:0] d;
      repeat (3) @(negedge clock);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_data", int'(out_data), 0);
      check("reset busy", int'(busy), 0);
      check("reset fifo_level", int'(fifo_level), 0);
      check("reset errs", int'({err_frame, err_overrun, err_parity}), 0);
      reset = 1'b0;
      bit_cycles(1'b1, 10);

      // Single byte with a ready consumer.
      out_ready = 1'b1;
      rxlog.delete();
      send_byte(8'hA5, 1'b1, 1'b0);
      bit_cycles(1'b1, 20);
      check("A5 count", rxlog.size(), 1);
      if (rxlog.size() > 0) check("A5 data", int'(rxlog[0]), 8'hA5);
      check("A5 errs", int'({err_frame, err_overrun, err_parity}), 0);

      // Short low glitch on an idle line.
      bit_cycles(1'b0, 4);
      bit_cycles(1'b1, 30);
      check("glitch count", rxlog.size(), 1);
      check("glitch busy", int'(busy), 0);
      check("glitch errs", int'({err_frame, err_overrun, err_parity}), 0);

      // Low stop bit followed by a break.
      send_byte(8'h3C, 1'b0, 1'b0);
      bit_cycles(1'b0, 40);
      check("break err_frame", int'(err_frame), 1);
      check("break busy", int'(busy), 1);
      check("break level", int'(fifo_level), 0);
      bit_cycles(1'b1, 20);
      check("break released busy", int'(busy), 0);
      send_byte(8'h55, 1'b1, 1'b0);
      bit_cycles(1'b1, 20);
      check("55 count", rxlog.size(), 2);
      if (rxlog.size() > 1) check("55 data", int'(rxlog[1]), 8'h55);
      pulse_clear();
      check("err_frame cleared", int'(err_frame), 0);

      // Overrun: five bytes into a four-entry FIFO with no consumer.
      out_ready = 1'b0;
      for (int b = 1; b <= 5; b++) begin
         d = 8'(b);
         send_byte(d, 1'b1, ^d);
         bit_cycles(1'b1, 4);
      end
      bit_cycles(1'b1, 10);
      check("full level", int'(fifo_level), 4);
      check("model full level", mq.size(), 4);
      check("overrun set", int'(err_overrun), 1);
      check("model overrun", int'(m_eo), 1);
      check("full head", int'(out_data), 8'h01);
      pulse_clear();
      check("overrun cleared", int'(err_overrun), 0);

      // Sixth byte, consumer ready only in the stop-sample cycle.
      stop_edge = cyc + 1 + 2 + H + (9 + P) * C;
      fork
         send_byte(8'h06, 1'b1, 1'b0);
         begin
            while (cyc < stop_edge - 1) @(negedge clock);
            out_ready = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
         end
      join
      bit_cycles(1'b1, 10);
      check("push+pop level", int'(fifo_level), 4);
      check("push+pop no overrun", int'(err_overrun), 0);
      check("push+pop head", int'(out_data), 8'h02);
      rxlog.delete();
      out_ready = 1'b1;
      bit_cycles(1'b1, 10);
      check("drain count", rxlog.size(), 4);
      if (rxlog.size() == 4) begin
         check("drain 0", int'(rxlog[0]), 8'h02);
         check("drain 1", int'(rxlog[1]), 8'h03);
         check("drain 2", int'(rxlog[2]), 8'h04);
         check("drain 3", int'(rxlog[3]), 8'h06);
      end
      check("drained level", int'(fifo_level), 0);

      // Reset in the middle of a frame with one byte buffered.
      out_ready = 1'b0;
      send_byte(8'h11, 1'b1, 1'b0);
      bit_cycles(1'b1, 10);
      check("pre-reset level", int'(fifo_level), 1);
      bit_cycles(1'b0, C);
      bit_cycles(1'b0, C);
      bit_cycles(1'b1, C);
      bit_cycles(1'b1, H);
      check("mid-frame busy", int'(busy), 1);
      reset = 1'b1;
      uart_rx = 1'b1;
      @(negedge clock);
      check("rst out_valid", int'(out_valid), 0);
      check("rst out_data", int'(out_data), 0);
      check("rst busy", int'(busy), 0);
      check("rst level", int'(fifo_level), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      bit_cycles(1'b1, 10);
      out_ready = 1'b1;
      rxlog.delete();
      send_byte(8'h81, 1'b1, 1'b0);
      bit_cycles(1'b1, 20);
      check("81 count", rxlog.size(), 1);
      if (rxlog.size() > 0) check("81 data", int'(rxlog[0]), 8'h81);

`ifdef UART_RX_PARITY_EN
      rxlog.delete();
      send_byte(8'h07, 1'b1, 1'b0);
      bit_cycles(1'b1, 20);
      check("bad parity flag", int'(err_parity), 1);
      check("bad parity dropped", rxlog.size(), 0);
      send_byte(8'h07, 1'b1, 1'b1);
      bit_cycles(1'b1, 20);
      check("good parity count", rxlog.size(), 1);
      if (rxlog.size() > 0) check("good parity data", int'(rxlog[0]), 8'h07);
`endif

      // Random frames, glitches, bad stop/parity bits, random ready and clear.
      rand_mode = 1'b1;
      for (int it = 0; it < 24; it++) begin
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) begin
            bit_cycles(1'b0, $urandom_range(1, 7));
            bit_cycles(1'b1, $urandom_range(10, 20));
         end
         send_byte(d, ($urandom_range(0, 7) != 0), (^d) ^ ($urandom_range(0, 7) == 0));
         bit_cycles(1'b1, $urandom_range(2, 30));
      end
      rand_mode = 1'b0;
      err_clear = 1'b0;
      out_ready = 1'b1;
      bit_cycles(1'b1, 40);
      check("final level", int'(fifo_level), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
